writeback_pipe_unit: RTL and testbench
======================================

Name: writeback_pipe_unit

Overview:
- Registered, parametrised write-back stage for the MIPS pipeline, placed between the MEM/WB boundary and the register file.
- Selects the write data from three sources: ALU result, load data, or PC link value for JAL.
- Adds sub-word load extraction and sign/zero extension, suppression of writes to register 0, and a multi-cycle load wait with stall back-pressure.
- Presents a registered commit port, and a same-cycle forwarding port for the hazard unit.

Parameters:
- DATA_WIDTH, 32, datapath width; must be a multiple of 8 and at least 16.
- REG_ADDR_WIDTH, 5, register-file index width.
- LINK_REG, 31, destination index forced on jump-and-link.
- OFFSET_WIDTH, 2, byte-offset width; equals log2(DATA_WIDTH/8).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous active-low reset.
- ValidIn  in  1  MEM stage presents an instruction this cycle.
- FlushIn  in  1  discard any held or waiting instruction.
- RegWriteIn  in  1  instruction writes the register file.
- MemToRegIn  in  1  write data comes from memory.
- JumpIn  in  2  jump type; nonzero selects the link write.
- LoadSizeIn  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- LoadSignedIn  in  1  1 sign-extends sub-word loads, 0 zero-extends.
- ByteOffsetIn  in  OFFSET_WIDTH  low address bits of the load.
- ALUIn  in  DATA_WIDTH  ALU result.
- MemoryReadDataIn  in  DATA_WIDTH  raw memory word.
- MemDataValidIn  in  1  MemoryReadDataIn is valid this cycle.
- DestinationRegIn  in  REG_ADDR_WIDTH  rd/rt destination.
- PCValueForJALIn  in  DATA_WIDTH  return address.
- StallOut  out  1  upstream must hold; combinational from state and inputs.
- RegWriteOut  out  1  register-file write enable, registered.
- RegWriteDataOut  out  DATA_WIDTH  write data, registered.
- DestinationRegOut  out  REG_ADDR_WIDTH  write index, registered.
- FwdValidOut  out  1  equals RegWriteOut.
- FwdRegOut  out  REG_ADDR_WIDTH  equals DestinationRegOut.
- FwdDataOut  out  DATA_WIDTH  equals RegWriteDataOut.

Behaviour:
- Reset (Rst low, asynchronous): state IDLE; all outputs 0; captured fields cleared.
- FSM states: IDLE, WAIT_MEM.
- IDLE, ValidIn=1, and not (MemToRegIn=1 and MemDataValidIn=0):
  - Compute write data and commit at the next edge (latency 1).
  - RegWriteOut=1 for exactly that one cycle, if the effective write enable is set.
- IDLE, ValidIn=1, MemToRegIn=1, MemDataValidIn=0:
  - Latch all control fields and ALUIn; go to WAIT_MEM; RegWriteOut=0.
- WAIT_MEM:
  - StallOut=1; ValidIn is ignored.
  - When MemDataValidIn=1: StallOut=0 that cycle, commit at the edge using the latched fields and the live memory data, return to IDLE.
  - Load and ValidIn arriving on the same cycle is impossible because StallOut held upstream until this cycle.
- StallOut is combinational: (state==WAIT_MEM and not MemDataValidIn) or (state==IDLE and ValidIn and MemToRegIn and not MemDataValidIn).
- Data select priority: JumpIn!=0 gives PCValueForJALIn; else MemToReg gives the extracted load; else ALUIn.
- Destination: LINK_REG when JumpIn!=0, else DestinationRegIn.
- Effective write enable: RegWriteIn and (effective destination != 0). JR (jump with RegWriteIn=0) produces no write.
- Load extraction:
  - Byte: lane ByteOffsetIn (lane 0 = bits 7:0).
  - Halfword: lane ByteOffsetIn[OFFSET_WIDTH-1:1].
  - The selected lane is extended to DATA_WIDTH by LoadSignedIn.
  - Word ignores the offset.
  - A misaligned halfword uses the truncated offset; no exception is raised.
- FlushIn:
  - Synchronous; wins over ValidIn and MemDataValidIn.
  - Next edge: state IDLE, RegWriteOut=0.
  - Data and destination outputs hold their previous values.
- Non-write cycles: RegWriteOut=0; data and destination outputs hold their last values.
- Reset asserted mid-WAIT_MEM: returns to IDLE immediately, asynchronously.
- Forwarding outputs are wires off the registered outputs; they add no cycle.

Test Plan:
- ALU op: ALUIn=0x0000_1234, RegWriteIn=1, Dest=8, ValidIn=1 → next cycle RegWriteOut=1, Data=0x1234, Dest=8; the following cycle RegWriteOut=0.
- Signed byte load: Mem=0x80FF_7F01, Offset=3, LoadSize=10, Signed=1, DataValid=1 → Data=0xFFFF_FF80. Same stimulus with Signed=0 → 0x0000_0080. Halfword with Offset=2, Signed=1 → 0xFFFF_80FF.
- JAL: JumpIn=01, PC=0x0040_0010, Dest=4, RegWriteIn=1 → Data=0x0040_0010, Dest=31. JumpIn=10 with RegWriteIn=0 → RegWriteOut stays 0.
- Multi-cycle load: load with DataValid low for 3 cycles → StallOut=1 for 3 cycles, no write. DataValid=1 with Mem=0xDEAD_BEEF (word) → StallOut=0 that cycle, next cycle commit of 0xDEAD_BEEF.
- Register 0: Dest=0, RegWriteIn=1, ALUIn=5 → RegWriteOut=0.
- Flush and reset: FlushIn during WAIT_MEM → no commit, StallOut=0 next cycle. Rst low mid-WAIT_MEM → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/writeback_pipe_unit.sv
`default_nettype none
// ============================================================================
// writeback_pipe_unit : MIPS write-back stage with sub-word load extraction,
//                       multi-cycle load wait and a same-cycle forwarding port.
// Revision: 1.0
// ============================================================================
module writeback_pipe_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_REG       = 31,
    parameter int OFFSET_WIDTH   = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      ValidIn,
    input  logic                      FlushIn,
    input  logic                      RegWriteIn,
    input  logic                      MemToRegIn,
    input  logic [1:0]                JumpIn,
    input  logic [1:0]                LoadSizeIn,
    input  logic                      LoadSignedIn,
    input  logic [OFFSET_WIDTH-1:0]   ByteOffsetIn,
    input  logic [DATA_WIDTH-1:0]     ALUIn,
    input  logic [DATA_WIDTH-1:0]     MemoryReadDataIn,
    input  logic                      MemDataValidIn,
    input  logic [REG_ADDR_WIDTH-1:0] DestinationRegIn,
    input  logic [DATA_WIDTH-1:0]     PCValueForJALIn,
    output logic                      StallOut,
    output logic                      RegWriteOut,
    output logic [DATA_WIDTH-1:0]     RegWriteDataOut,
    output logic [REG_ADDR_WIDTH-1:0] DestinationRegOut,
    output logic                      FwdValidOut,
    output logic [REG_ADDR_WIDTH-1:0] FwdRegOut,
    output logic [DATA_WIDTH-1:0]     FwdDataOut
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Fields of a load parked while memory data is outstanding
    logic                      regwrite_q;
    logic                      memtoreg_q;
    logic [1:0]                jump_q;
    logic [1:0]                size_q;
    logic                      signed_q;
    logic [OFFSET_WIDTH-1:0]   offset_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;

    logic                      wr_en_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic [REG_ADDR_WIDTH-1:0] wr_dest_q;

    logic                      sel_regwrite;
    logic                      sel_memtoreg;
    logic [1:0]                sel_jump;
    logic [1:0]                sel_size;
    logic                      sel_signed;
    logic [OFFSET_WIDTH-1:0]   sel_offset;
    logic [DATA_WIDTH-1:0]     sel_alu;
    logic [DATA_WIDTH-1:0]     sel_pc;
    logic [REG_ADDR_WIDTH-1:0] sel_dest;

    logic                      fire;
    logic                      capture;
    logic [REG_ADDR_WIDTH-1:0] eff_dest;
    logic                      eff_we;
    logic [DATA_WIDTH-1:0]     byte_shift;
    logic [DATA_WIDTH-1:0]     half_shift;
    logic [OFFSET_WIDTH-1:0]   half_idx;
    logic [7:0]                byte_lane;
    logic [15:0]               half_lane;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     wb_data;

    always_comb begin
        if (state_q == ST_WAIT_MEM) begin
            sel_regwrite = regwrite_q;
            sel_memtoreg = memtoreg_q;
            sel_jump     = jump_q;
            sel_size     = size_q;
            sel_signed   = signed_q;
            sel_offset   = offset_q;
            sel_alu      = alu_q;
            sel_pc       = pc_q;
            sel_dest     = dest_q;
        end else begin
            sel_regwrite = RegWriteIn;
            sel_memtoreg = MemToRegIn;
            sel_jump     = JumpIn;
            sel_size     = LoadSizeIn;
            sel_signed   = LoadSignedIn;
            sel_offset   = ByteOffsetIn;
            sel_alu      = ALUIn;
            sel_pc       = PCValueForJALIn;
            sel_dest     = DestinationRegIn;
        end
    end

    // Halfword lane index is the offset with its low bit dropped
    generate
        if (OFFSET_WIDTH > 1) begin : g_half_idx_wide
            assign half_idx = {1'b0, sel_offset[OFFSET_WIDTH-1:1]};
        end else begin : g_half_idx_narrow
            assign half_idx = '0;
        end
    endgenerate

    assign byte_shift = MemoryReadDataIn >> {sel_offset, 3'b000};
    assign half_shift = MemoryReadDataIn >> {half_idx, 4'b0000};
    assign byte_lane  = byte_shift[7:0];
    assign half_lane  = half_shift[15:0];

    always_comb begin
        case (sel_size)
            2'b10:   load_data = {{(DATA_WIDTH-8){sel_signed & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{(DATA_WIDTH-16){sel_signed & half_lane[15]}}, half_lane};
            default: load_data = MemoryReadDataIn;
        endcase
    end

    always_comb begin
        if (sel_jump != 2'b00) begin
            wb_data  = sel_pc;
            eff_dest = REG_ADDR_WIDTH'(LINK_REG);
        end else begin
            wb_data  = sel_memtoreg ? load_data : sel_alu;
            eff_dest = sel_dest;
        end
        eff_we = sel_regwrite && (eff_dest != '0);
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ValidIn) begin
                    if (MemToRegIn && !MemDataValidIn) begin
                        capture = 1'b1;
                        state_d = ST_WAIT_MEM;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (MemDataValidIn) begin
                    fire    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (FlushIn) begin
            state_d = ST_IDLE;
            fire    = 1'b0;
            capture = 1'b0;
        end
    end

    assign StallOut = ((state_q == ST_WAIT_MEM) && !MemDataValidIn) ||
                      ((state_q == ST_IDLE) && ValidIn && MemToRegIn && !MemDataValidIn);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            jump_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            offset_q   <= '0;
            alu_q      <= '0;
            pc_q       <= '0;
            dest_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                regwrite_q <= RegWriteIn;
                memtoreg_q <= MemToRegIn;
                jump_q     <= JumpIn;
                size_q     <= LoadSizeIn;
                signed_q   <= LoadSignedIn;
                offset_q   <= ByteOffsetIn;
                alu_q      <= ALUIn;
                pc_q       <= PCValueForJALIn;
                dest_q     <= DestinationRegIn;
            end
            // Data and index only move on a real write so the hazard unit
            // keeps seeing the last committed value.
            wr_en_q <= fire && eff_we;
            if (fire && eff_we) begin
                wr_data_q <= wb_data;
                wr_dest_q <= eff_dest;
            end
        end
    end

    assign RegWriteOut       = wr_en_q;
    assign RegWriteDataOut   = wr_data_q;
    assign DestinationRegOut = wr_dest_q;
    assign FwdValidOut       = wr_en_q;
    assign FwdRegOut         = wr_dest_q;
    assign FwdDataOut        = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_pipe_unit.sv
`default_nettype none
// ============================================================================
// tb_writeback_pipe_unit : directed and randomized checks against a
//                          transaction-level model of the write-back stage.
// Revision: 1.0
// ============================================================================
module tb_writeback_pipe_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ValidIn, FlushIn, RegWriteIn, MemToRegIn, LoadSignedIn, MemDataValidIn;
    logic [1:0]  JumpIn, LoadSizeIn, ByteOffsetIn;
    logic [31:0] ALUIn, MemoryReadDataIn, PCValueForJALIn;
    logic [4:0]  DestinationRegIn;
    wire         StallOut, RegWriteOut, FwdValidOut;
    wire  [31:0] RegWriteDataOut, FwdDataOut;
    wire  [4:0]  DestinationRegOut, FwdRegOut;

    writeback_pipe_unit dut (
        .Clk(Clk), .Rst(Rst), .ValidIn(ValidIn), .FlushIn(FlushIn),
        .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .JumpIn(JumpIn),
        .LoadSizeIn(LoadSizeIn), .LoadSignedIn(LoadSignedIn), .ByteOffsetIn(ByteOffsetIn),
        .ALUIn(ALUIn), .MemoryReadDataIn(MemoryReadDataIn), .MemDataValidIn(MemDataValidIn),
        .DestinationRegIn(DestinationRegIn), .PCValueForJALIn(PCValueForJALIn),
        .StallOut(StallOut), .RegWriteOut(RegWriteOut), .RegWriteDataOut(RegWriteDataOut),
        .DestinationRegOut(DestinationRegOut), .FwdValidOut(FwdValidOut),
        .FwdRegOut(FwdRegOut), .FwdDataOut(FwdDataOut)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    logic s_stall;

    // Reference model: one optional parked load plus the committed outputs
    bit          m_pend;
    logic        p_rw, p_sg;
    logic [1:0]  p_jmp, p_sz, p_off;
    logic [31:0] p_alu, p_pc;
    logic [4:0]  p_dest;
    logic        m_we;
    logic [31:0] m_data;
    logic [4:0]  m_dest;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] mem, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
        longint m = longint'(mem);
        longint lane;
        case (size)
            2'd2: begin
                lane = (m / (64'd1 << (8 * off))) % 256;
                if (sgn && lane >= 128) lane = lane - 256;
                return 32'(lane);
            end
            2'd1: begin
                lane = (m / (64'd1 << (16 * (off / 2)))) % 65536;
                if (sgn && lane >= 32768) lane = lane - 65536;
                return 32'(lane);
            end
            default: return mem;
        endcase
    endfunction

    task automatic model_commit(input logic rw, input logic [1:0] jmp, input logic [4:0] dest,
                                input logic [31:0] data);
        logic [4:0] d;
        d = (jmp != 0) ? 5'd31 : dest;
        m_we = rw && (d != 0);
        if (m_we) begin
            m_data = data;
            m_dest = d;
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_we = 0; m_data = 0; m_dest = 0;
    endtask

    task automatic model_step();
        logic [31:0] v;
        if (FlushIn) begin
            m_pend = 0;
            m_we   = 0;
        end else if (m_pend) begin
            if (MemDataValidIn) begin
                v = (p_jmp != 0) ? p_pc : load_val(MemoryReadDataIn, p_sz, p_sg, p_off);
                model_commit(p_rw, p_jmp, p_dest, v);
                m_pend = 0;
            end else begin
                m_we = 0;
            end
        end else if (ValidIn) begin
            if (MemToRegIn && !MemDataValidIn) begin
                m_pend = 1; p_rw = RegWriteIn; p_jmp = JumpIn; p_sz = LoadSizeIn;
                p_sg = LoadSignedIn; p_off = ByteOffsetIn; p_alu = ALUIn;
                p_pc = PCValueForJALIn; p_dest = DestinationRegIn;
                m_we = 0;
            end else begin
                if (JumpIn != 0) v = PCValueForJALIn;
                else if (MemToRegIn) v = load_val(MemoryReadDataIn, LoadSizeIn, LoadSignedIn, ByteOffsetIn);
                else v = ALUIn;
                model_commit(RegWriteIn, JumpIn, DestinationRegIn, v);
            end
        end else begin
            m_we = 0;
        end
    endtask

    function automatic logic exp_stall();
        if (m_pend) return !MemDataValidIn;
        return ValidIn && MemToRegIn && !MemDataValidIn;
    endfunction

    // Inputs are set one unit after a rising edge; this checks stall, then outputs after the edge
    task automatic cycle();
        #1;
        s_stall = StallOut;
        chk_eq("stall", StallOut, exp_stall());
        @(posedge Clk);
        model_step();
        #1;
        chk_eq("we",      RegWriteOut,       m_we);
        chk_eq("data",    RegWriteDataOut,   m_data);
        chk_eq("dest",    DestinationRegOut, m_dest);
        chk_eq("fwd_v",   FwdValidOut,       m_we);
        chk_eq("fwd_reg", FwdRegOut,         m_dest);
        chk_eq("fwd_dat", FwdDataOut,        m_data);
    endtask

    task automatic idle();
        ValidIn = 0; FlushIn = 0; RegWriteIn = 0; MemToRegIn = 0; JumpIn = 0;
        LoadSizeIn = 0; LoadSignedIn = 0; ByteOffsetIn = 0; ALUIn = 0;
        MemoryReadDataIn = 0; MemDataValidIn = 0; DestinationRegIn = 0; PCValueForJALIn = 0;
    endtask

    task automatic async_reset();
        Rst = 0;
        #1;
        chk_eq("rst_we",    RegWriteOut,       0);
        chk_eq("rst_data",  RegWriteDataOut,   0);
        chk_eq("rst_dest",  DestinationRegOut, 0);
        model_reset();
        #2;
        Rst = 1;
    endtask

    initial begin
        idle();
        model_reset();
        Rst = 0;
        #3;
        chk_eq("reset_we",    RegWriteOut,       0);
        chk_eq("reset_data",  RegWriteDataOut,   0);
        chk_eq("reset_stall", StallOut,          0);
        #9 Rst = 1;
        @(posedge Clk); #1;

        // ALU write, then a cycle with no instruction
        ValidIn = 1; RegWriteIn = 1; ALUIn = 32'h0000_1234; DestinationRegIn = 8;
        cycle();
        chk_eq("alu_we", RegWriteOut, 1);
        chk_eq("alu_data", RegWriteDataOut, 32'h1234);
        chk_eq("alu_dest", DestinationRegOut, 8);
        idle(); cycle();
        chk_eq("alu_we_drop", RegWriteOut, 0);

        // Sub-word loads
        idle(); ValidIn = 1; RegWriteIn = 1; MemToRegIn = 1; MemDataValidIn = 1;
        MemoryReadDataIn = 32'h80FF_7F01; ByteOffsetIn = 3; LoadSizeIn = 2'b10;
        LoadSignedIn = 1; DestinationRegIn = 9;
        cycle(); chk_eq("lb", RegWriteDataOut, 32'hFFFF_FF80);
        LoadSignedIn = 0;
        cycle(); chk_eq("lbu", RegWriteDataOut, 32'h0000_0080);
        LoadSizeIn = 2'b01; ByteOffsetIn = 2; LoadSignedIn = 1;
        cycle(); chk_eq("lh", RegWriteDataOut, 32'hFFFF_80FF);

        // Jump and link, then JR
        idle(); ValidIn = 1; JumpIn = 2'b01; PCValueForJALIn = 32'h0040_0010;
        DestinationRegIn = 4; RegWriteIn = 1;
        cycle();
        chk_eq("jal_data", RegWriteDataOut, 32'h0040_0010);
        chk_eq("jal_dest", DestinationRegOut, 31);
        JumpIn = 2'b10; RegWriteIn = 0;
        cycle(); chk_eq("jr_we", RegWriteOut, 0);

        // Multi-cycle load: three stalled cycles then the data arrives
        idle(); ValidIn = 1; MemToRegIn = 1; RegWriteIn = 1; DestinationRegIn = 10;
        cycle(); chk_eq("mc_stall0", s_stall, 1);
        idle(); cycle(); chk_eq("mc_stall1", s_stall, 1);
        cycle(); chk_eq("mc_stall2", s_stall, 1);
        chk_eq("mc_nowrite", RegWriteOut, 0);
        MemDataValidIn = 1; MemoryReadDataIn = 32'hDEAD_BEEF;
        cycle();
        chk_eq("mc_stall_rel", s_stall, 0);
        chk_eq("mc_we", RegWriteOut, 1);
        chk_eq("mc_data", RegWriteDataOut, 32'hDEAD_BEEF);
        chk_eq("mc_dest", DestinationRegOut, 10);

        // Register zero is never written
        idle(); ValidIn = 1; RegWriteIn = 1; ALUIn = 5; DestinationRegIn = 0;
        cycle(); chk_eq("r0_we", RegWriteOut, 0);
        chk_eq("r0_hold", RegWriteDataOut, 32'hDEAD_BEEF);

        // Flush while waiting on memory
        idle(); ValidIn = 1; MemToRegIn = 1; RegWriteIn = 1; DestinationRegIn = 12;
        cycle();
        idle(); FlushIn = 1; cycle();
        idle(); MemDataValidIn = 1; MemoryReadDataIn = 32'h1111_2222;
        cycle();
        chk_eq("flush_stall", s_stall, 0);
        chk_eq("flush_we", RegWriteOut, 0);

        // Asynchronous reset while waiting on memory
        idle(); ValidIn = 1; MemToRegIn = 1; RegWriteIn = 1; DestinationRegIn = 13;
        cycle();
        idle(); cycle();
        async_reset();
        idle(); cycle();
        chk_eq("rst_idle_stall", s_stall, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                idle();
                async_reset();
            end
            ValidIn          = ($urandom_range(0, 9) < 6);
            FlushIn          = ($urandom_range(0, 19) == 0);
            RegWriteIn       = ($urandom_range(0, 9) < 8);
            MemToRegIn       = ($urandom_range(0, 9) < 4);
            JumpIn           = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            LoadSizeIn       = 2'($urandom);
            LoadSignedIn     = 1'($urandom);
            ByteOffsetIn     = 2'($urandom);
            ALUIn            = $urandom;
            MemoryReadDataIn = $urandom;
            MemDataValidIn   = 1'($urandom);
            DestinationRegIn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            PCValueForJALIn  = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
